rsa_modexp_engine: RTL and testbench
====================================

RSA_MODEXP_ENGINE -- requirements
Module: rsa_modexp_engine

Interface
REQ-001 The block SHALL have parameter W, default 64: modulus, operand and result width in bits.
REQ-002 The block SHALL have parameter EW, default W: exponent width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port mod_we, input, 1 bit: write strobe for the modulus register.
REQ-006 The block SHALL have port mod_data, input, W bits: modulus n.
REQ-007 The block SHALL have port key_we, input, 1 bit: write strobe for the exponent register selected by key_sel.
REQ-008 The block SHALL have port key_sel, input, 1 bit: 0 selects e (encrypt key), 1 selects d (decrypt key).
REQ-009 The block SHALL have port key_data, input, EW bits: exponent value.
REQ-010 The block SHALL have port in_valid, input, 1 bit: operand offered.
REQ-011 The block SHALL have port in_ready, output, 1 bit: engine can accept an operand.
REQ-012 The block SHALL have port in_mode, input, 1 bit: 0 encrypt (use e), 1 decrypt (use d).
REQ-013 The block SHALL have port in_data, input, W bits: plaintext or ciphertext operand.
REQ-014 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-015 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 The block SHALL have port out_data, output, W bits: in_data^exp mod n.
REQ-017 The block SHALL have port out_err, output, 1 bit: result invalid; qualified by out_valid.
REQ-018 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-019 Register writes (mod_we, key_we) SHALL take effect at the clock edge and SHALL be ignored while busy=1.
REQ-020 in_ready SHALL equal (state==IDLE); an operand SHALL be accepted on any edge where in_valid and in_ready are both high, latching in_data and the exponent selected by in_mode.
REQ-021 The FSM SHALL have states IDLE, LOAD, STEP, OUT with the following transitions:
- IDLE->LOAD on accept;
- LOAD->OUT if the input is an error or the exponent is 0;
- LOAD->STEP otherwise;
- STEP->STEP while the remaining exponent is nonzero after the shift;
- STEP->OUT when the remaining exponent is zero after the shift;
- OUT->IDLE on out_valid and out_ready both high.
REQ-022 An error SHALL be flagged when n<2 or in_data>=n; an error SHALL produce out_err=1 and out_data=0.
REQ-023 Exponentiation SHALL be right-to-left binary: init result=1 and base=in_data; per STEP, if exp[0]=1 then result=result*base mod n; base=base*base mod n; then exp>>=1.
REQ-024 Each STEP SHALL run both products concurrently on two rsa_modmul instances and SHALL last exactly W+1 cycles.
REQ-025 With k = index of the exponent's highest set bit plus 1 (k=0 for exponent 0), out_valid SHALL rise exactly 2+k*(W+1) cycles after the accept edge; for error cases it SHALL rise exactly 2 cycles after the accept edge.
REQ-026 Exponent 0 with a valid input SHALL give out_data=1 and out_err=0.
REQ-027 out_valid, out_data and out_err SHALL be held stable until out_ready is high.
REQ-028 out_valid SHALL drop the cycle after the handshake; a new operand SHALL NOT be accepted in the handshake cycle itself.
REQ-029 rsa_modmul SHALL compute a*b mod n by interleaved MSB-first shift-add:
- r=2r, subtract n if r>=n;
- if the current a bit is 1, r=r+b, subtract n if r>=n;
- one bit per cycle, W cycles, plus one start cycle.
REQ-030 rsa_modmul SHALL keep intermediates at W+2 bits, SHALL require a,b<n, and SHALL use no divide or % operator.

Reset
REQ-031 Asserting rst SHALL force, asynchronously:
- state=IDLE;
- out_valid=0, out_err=0, out_data=0;
- busy=0, in_ready=0 while rst is high;
- n, e, d and all datapath registers to 0.
REQ-032 Reset mid-operation SHALL abort the operation with no output produced; in_ready SHALL be 1 in the first cycle after rst is released.

Structure
REQ-033 A shared package rsa_pkg SHALL hold:
- the FSM state encoding;
- the MODE_ENC=0 and MODE_DEC=1 constants;
- the default widths W_DEF=64 and EW_DEF=64.
REQ-034 One sub-module, rsa_modmul (parameter W; ports start/done handshake, a, b, n, r), SHALL be instantiated twice: once as the square unit and once as the multiply unit.

Verification (W=EW=8)
REQ-035 Bench SHALL cover encrypt: n=33, e=3, in_data=4, mode 0 -> out_data=31, out_err=0, out_valid exactly 20 cycles after accept.
REQ-036 Bench SHALL cover decrypt: d=7, in_data=31, mode 1 -> out_data=4; back-to-back encrypt then decrypt SHALL round-trip values 0..32.
REQ-037 Bench SHALL cover errors: n=33, in_data=33 -> out_err=1, out_data=0 after 2 cycles; n=1, in_data=0 -> out_err=1.
REQ-038 Bench SHALL cover exponent 0: e=0, n=33, in_data=5 -> out_data=1 after 2 cycles.
REQ-039 Bench SHALL cover back-pressure and write protection: out_ready held low for 10 cycles -> out_valid/out_data stable, in_ready=0; key_we while busy -> the next result still uses the old key.
REQ-040 Bench SHALL cover reset mid-STEP: rst pulsed -> out_valid=0, in_ready=1 in the cycle after release, and the next operation is correct after reloading keys.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation engine:
// FSM state encoding, key-select/mode constants and default widths.
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_STEP = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int unsigned W_DEF  = 64;
  localparam int unsigned EW_DEF = 64;

endpackage

// File: rtl/rsa_modmul.sv
// Serial modular multiplier: r = a*b mod n by MSB-first interleaved shift-add,
// one multiplier bit per cycle. Requires a, b < n.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] r
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_n;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic          w_bit;
  logic [W-1:0]  w_acc_in;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_n;
  logic [W-1:0]  w_step;

  // One interleaved iteration; accumulator headroom is two bits above W.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc,
                                           input logic         bit_a,
                                           input logic [W-1:0] bv,
                                           input logic [W-1:0] nv);
    logic [W+1:0] t;
    logic [W+1:0] n_ext;
    logic [W+1:0] b_ext;
    n_ext = {2'b00, nv};
    b_ext = {2'b00, bv};
    t     = {1'b0, acc, 1'b0};
    if (t >= n_ext) t = t - n_ext;
    if (bit_a) begin
      t = t + b_ext;
      if (t >= n_ext) t = t - n_ext;
    end
    return W'(t);
  endfunction

  // The start cycle already consumes the top bit of a, so W bits take W+1 cycles.
  always_comb begin
    w_bit    = start ? a[W-1] : r_a[W-1];
    w_acc_in = start ? '0 : r_acc;
    w_b      = start ? b : r_b;
    w_n      = start ? n : r_n;
    w_step   = mm_step(w_acc_in, w_bit, w_b, w_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a    <= {a[W-2:0], 1'b0};
        r_b    <= b;
        r_n    <= n;
        r_acc  <= w_step;
        r_cnt  <= CW'(W - 1);
        r_busy <= (W != 1);
        r_done <= (W == 1);
      end else if (r_busy) begin
        r_a   <= {r_a[W-2:0], 1'b0};
        r_acc <= w_step;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign r    = r_acc;

endmodule

// File: rtl/rsa_modexp_engine.sv
// RSA modular exponentiation engine: right-to-left binary exponentiation with
// concurrent square and multiply units, keyed by registered n, e and d.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned EW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mod_we,
  input  logic [W-1:0]  mod_data,
  input  logic          key_we,
  input  logic          key_sel,
  input  logic [EW-1:0] key_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_err,
  output logic          busy
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_n;
  logic [EW-1:0] r_key_e;
  logic [EW-1:0] r_key_d;
  logic [EW-1:0] r_exp;
  logic [W-1:0]  r_base;
  logic [W-1:0]  r_result;
  logic          r_err;
  logic          r_start;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_err;

  logic          w_busy;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_in_err;
  logic [EW-1:0] w_exp_shift;
  logic          w_sq_done;
  logic          w_mul_done;
  logic          w_step_done;
  logic [W-1:0]  w_sq_r;
  logic [W-1:0]  w_mul_r;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_in_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept    = in_valid && w_in_ready;
  assign w_in_err    = (r_n < W'(2)) || (r_base >= r_n);
  assign w_exp_shift = r_exp >> 1;
  assign w_step_done = w_sq_done && w_mul_done;

  rsa_modmul #(.W(W)) u_square (
    .clk   (clk),
    .rst   (rst),
    .start (r_start),
    .a     (r_base),
    .b     (r_base),
    .n     (r_n),
    .done  (w_sq_done),
    .r     (w_sq_r)
  );

  rsa_modmul #(.W(W)) u_multiply (
    .clk   (clk),
    .rst   (rst),
    .start (r_start),
    .a     (r_result),
    .b     (r_base),
    .n     (r_n),
    .done  (w_mul_done),
    .r     (w_mul_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = (w_in_err || (r_exp == '0)) ? ST_OUT : ST_STEP;
      ST_STEP: if (w_step_done) w_state_nxt = (w_exp_shift != '0) ? ST_STEP : ST_OUT;
      ST_OUT:  if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath; out_valid is registered one cycle into OUT so errors and
  // exponent 0 report two cycles after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n         <= '0;
      r_key_e     <= '0;
      r_key_d     <= '0;
      r_exp       <= '0;
      r_base      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (!w_busy) begin
        if (mod_we) r_n <= mod_data;
        if (key_we) begin
          if (key_sel == MODE_DEC) r_key_d <= key_data;
          else                     r_key_e <= key_data;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base   <= in_data;
            r_result <= W'(1);
            r_exp    <= (in_mode == MODE_DEC) ? r_key_d : r_key_e;
            r_err    <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_err <= w_in_err;
          if (!w_in_err && (r_exp != '0)) r_start <= 1'b1;
        end
        ST_STEP: begin
          if (w_step_done) begin
            if (r_exp[0]) r_result <= w_mul_r;
            r_base <= w_sq_r;
            r_exp  <= w_exp_shift;
            if (w_exp_shift != '0) r_start <= 1'b1;
          end
        end
        ST_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_err ? '0 : r_result;
            r_out_err   <= r_err;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine at W=EW=8: vector table plus
// back-pressure, write-protect, round-trip and mid-operation reset sequences.
module tb_rsa_modexp_engine;
  import rsa_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mod_we;
  logic [W-1:0]  mod_data;
  logic          key_we;
  logic          key_sel;
  logic [EW-1:0] key_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  rsa_modexp_engine #(.W(W), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mod_we    (mod_we),
    .mod_data  (mod_data),
    .key_we    (key_we),
    .key_sel   (key_sel),
    .key_data  (key_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    int   n;
    int   key;
    int   data;
    int   exp_data;
    int   exp_err;
    int   exp_lat;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wr_mod(input int v);
    mod_we = 1'b1; mod_data = 8'(v);
    tick();
    mod_we = 1'b0;
  endtask

  task automatic wr_key(input logic sel, input int v);
    key_we = 1'b1; key_sel = sel; key_data = 8'(v);
    tick();
    key_we = 1'b0;
  endtask

  function automatic int powmod(input int b, input int e, input int m);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // Offer one operand, measure accept-to-out_valid latency, optionally stall
  // the consumer and/or attempt a key write while busy, then handshake.
  task automatic run_op(input string name, input logic mode, input int data,
                        input int exp_data, input int exp_err, input int exp_lat,
                        input int stall, input bit wkey, output int got);
    int lat = 0;
    got = -1;
    in_valid = 1'b1; in_mode = mode; in_data = 8'(data);
    chk({name, " in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    if (wkey) begin
      key_we = 1'b1; key_sel = mode; key_data = 8'd5;
    end
    while (!out_valid && lat < 400) begin
      tick();
      key_we = 1'b0;
      lat++;
    end
    if (!out_valid) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: no out_valid after %0d cycles, expected %0d", name, lat, exp_lat);
      do_reset();
      return;
    end
    got = int'(out_data);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " data"}, int'(out_data), exp_data);
    chk({name, " err"}, int'(out_err), exp_err);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({name, " stall valid"}, int'(out_valid), 1);
      chk({name, " stall data"}, int'(out_data), exp_data);
      chk({name, " stall err"}, int'(out_err), exp_err);
      chk({name, " stall in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    chk({name, " in_ready in handshake"}, int'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    chk({name, " valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int got;
    int enc;

    vec[0] = '{MODE_ENC,  33,   3,   4,  31, 0, 20};
    vec[1] = '{MODE_DEC,  33,   7,  31,   4, 0, 29};
    vec[2] = '{MODE_ENC,  33,   3,  33,   0, 1,  2};
    vec[3] = '{MODE_ENC,   1,   3,   0,   0, 1,  2};
    vec[4] = '{MODE_ENC,  33,   0,   5,   1, 0,  2};
    vec[5] = '{MODE_ENC,  33,   3,  32,  32, 0, 20};
    vec[6] = '{MODE_ENC, 255,   3, 254, 254, 0, 20};
    vec[7] = '{MODE_ENC, 251, 128,   2, 243, 0, 74};
    vec[8] = '{MODE_ENC,  33,   1,  32,  32, 0, 11};
    vec[9] = '{MODE_DEC,   2, 255,   1,   1, 0, 74};

    rst = 1'b1; mod_we = 1'b0; mod_data = '0; key_we = 1'b0; key_sel = 1'b0;
    key_data = '0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_err", int'(out_err), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      wr_mod(vec[i].n);
      wr_key(vec[i].mode, vec[i].key);
      run_op($sformatf("vec%0d", i), vec[i].mode, vec[i].data, vec[i].exp_data,
             vec[i].exp_err, vec[i].exp_lat, 0, 1'b0, got);
    end

    wr_mod(33);
    wr_key(MODE_ENC, 3);
    wr_key(MODE_DEC, 7);
    for (int x = 0; x < 33; x++) begin
      run_op($sformatf("rt_enc%0d", x), MODE_ENC, x, powmod(x, 3, 33), 0, 20, 0, 1'b0, enc);
      run_op($sformatf("rt_dec%0d", x), MODE_DEC, enc, x, 0, 29, 0, 1'b0, got);
    end

    run_op("backpressure", MODE_ENC, 4, 31, 0, 20, 10, 1'b1, got);
    run_op("old key kept", MODE_ENC, 4, 31, 0, 20, 0, 1'b0, got);

    in_valid = 1'b1; in_mode = MODE_DEC; in_data = 8'd31;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid-step busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("release in_ready", int'(in_ready), 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) break;
    end
    chk("aborted no output", int'(out_valid), 0);

    run_op("n cleared", MODE_ENC, 0, 0, 1, 2, 0, 1'b0, got);
    wr_mod(33);
    run_op("e cleared", MODE_ENC, 5, 1, 0, 2, 0, 1'b0, got);
    wr_key(MODE_ENC, 3);
    wr_key(MODE_DEC, 7);
    run_op("after reset enc", MODE_ENC, 4, 31, 0, 20, 0, 1'b0, got);
    run_op("after reset dec", MODE_DEC, 31, 4, 0, 29, 0, 1'b0, got);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
